// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - RV32I writeback stage: ALU pass-through, single-outstanding load, register file write port.
// Optional WB_MISALIGN_TRAP_EN: flag misaligned LH/LHU/LW with a one-cycle load_err instead of issuing them.
module wb_stage #(
    parameter int MODE       = 32,
    parameter int REG_NUMBER = 32,
    localparam int RW        = $clog2(REG_NUMBER)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_wr_en,
    input  logic [RW-1:0]   in_rd,
    input  logic [MODE-1:0] in_result,
    input  logic            in_is_load,
    input  logic [2:0]      in_funct3,
    output logic            mem_req,
    output logic [MODE-1:0] mem_addr,
    input  logic            mem_ack,
    input  logic [MODE-1:0] mem_rdata,
    output logic            rf_write,
    output logic [RW-1:0]   rf_sel_write_reg,
    output logic [MODE-1:0] rf_data_in,
    output logic            load_err,
    output logic            busy
);

    typedef enum logic {IDLE = 1'b0, MEM = 1'b1} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            r_mem_req;
    logic [MODE-1:0] r_mem_addr;
    logic            r_rf_write;
    logic [RW-1:0]   r_rf_sel;
    logic [MODE-1:0] r_rf_data;
    logic            r_load_err;
    logic            r_busy;
    logic [RW-1:0]   r_rd;
    logic            r_wr_en;
    logic [2:0]      r_funct3;
    logic [1:0]      r_lane;

    logic            w_accept;
    logic            w_misalign;
    logic            w_alu_we;
    logic            w_load_we;
    logic [MODE-1:0] w_load_data;

    // Byte lane picks the byte; only addr[1] picks the half.
    function automatic logic [MODE-1:0] format_load(input logic [MODE-1:0] word,
                                                    input logic [2:0]      f3,
                                                    input logic [1:0]      lane);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  return {{(MODE-8){b[7]}}, b};
            3'b001:  return {{(MODE-16){h[15]}}, h};
            3'b100:  return {{(MODE-8){1'b0}}, b};
            3'b101:  return {{(MODE-16){1'b0}}, h};
            default: return word;
        endcase
    endfunction

    assign in_ready    = (r_state == IDLE);
    assign w_accept    = in_valid & in_ready;
    assign w_alu_we    = in_wr_en & (in_rd != '0);
    assign w_load_we   = r_wr_en & (r_rd != '0);
    assign w_load_data = format_load(mem_rdata, r_funct3, r_lane);

`ifdef WB_MISALIGN_TRAP_EN
    // funct3[1] set covers LW and the reserved codes treated as LW.
    assign w_misalign = in_is_load &
                        (((in_funct3[1:0] == 2'b01) & in_result[0]) |
                         (in_funct3[1] & (in_result[1:0] != 2'b00)));
`else
    assign w_misalign = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept && in_is_load && !w_misalign) w_state_next = MEM;
            MEM:     if (mem_ack) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
            r_rf_write <= 1'b0;
            r_rf_sel   <= '0;
            r_rf_data  <= '0;
            r_load_err <= 1'b0;
            r_busy     <= 1'b0;
            r_rd       <= '0;
            r_wr_en    <= 1'b0;
            r_funct3   <= '0;
            r_lane     <= '0;
        end else begin
            r_state    <= w_state_next;
            r_rf_write <= 1'b0;
            r_load_err <= 1'b0;
            if (w_accept) begin
                if (!in_is_load) begin
                    r_rf_write <= w_alu_we;
                    if (w_alu_we) begin
                        r_rf_sel  <= in_rd;
                        r_rf_data <= in_result;
                    end
                end else if (w_misalign) begin
                    r_load_err <= 1'b1;
                end else begin
                    r_rd       <= in_rd;
                    r_wr_en    <= in_wr_en;
                    r_funct3   <= in_funct3;
                    r_lane     <= in_result[1:0];
                    r_mem_req  <= 1'b1;
                    r_mem_addr <= {in_result[MODE-1:2], 2'b00};
                    r_busy     <= 1'b1;
                end
            end else if (r_state == MEM && mem_ack) begin
                r_rf_write <= w_load_we;
                if (w_load_we) begin
                    r_rf_sel  <= r_rd;
                    r_rf_data <= w_load_data;
                end
                r_mem_req <= 1'b0;
                r_busy    <= 1'b0;
            end
        end
    end

    assign mem_req          = r_mem_req;
    assign mem_addr         = r_mem_addr;
    assign rf_write         = r_rf_write;
    assign rf_sel_write_reg = r_rf_sel;
    assign rf_data_in       = r_rf_data;
    assign load_err         = r_load_err;
    assign busy             = r_busy;

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - self-checking bench for wb_stage: directed cases plus randomized ALU/load mix.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_wr_en = 1'b0;
    logic [4:0]  in_rd = '0;
    logic [31:0] in_result = '0;
    logic        in_is_load = 1'b0;
    logic [2:0]  in_funct3 = '0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        rf_write;
    logic [4:0]  rf_sel_write_reg;
    logic [31:0] rf_data_in;
    logic        load_err;
    logic        busy;

    int total = 0;
    int bad   = 0;
    logic [4:0]  exp_sel  = '0;
    logic [31:0] exp_data = '0;

    wb_stage dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_wr_en(in_wr_en), .in_rd(in_rd),
        .in_result(in_result), .in_is_load(in_is_load), .in_funct3(in_funct3),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .rf_write(rf_write), .rf_sel_write_reg(rf_sel_write_reg), .rf_data_in(rf_data_in),
        .load_err(load_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [2:0] f3,
                                             input logic [31:0] addr);
        logic [31:0] b, h;
        b = (word >> (8 * addr[1:0])) & 32'hFF;
        h = (word >> (addr[1] ? 16 : 0)) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'h80) ? b - 32'h100 : b;
            3'd1:    return (h >= 32'h8000) ? h - 32'h1_0000 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return word;
        endcase
    endfunction

    function automatic bit ref_misaligned(input logic [2:0] f3, input logic [31:0] addr);
`ifdef WB_MISALIGN_TRAP_EN
        bit is_lh, is_lw;
        is_lh = (f3 == 3'd1) || (f3 == 3'd5);
        is_lw = (f3 == 3'd2) || (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
        return (is_lh && addr[0]) || (is_lw && (addr % 4 != 0));
`else
        return 1'b0;
`endif
    endfunction

    // Called at a negedge; drives one ALU op and checks its writeback at the next negedge.
    task automatic alu_op(input logic [4:0] rd, input logic wr, input logic [31:0] res);
        bit we;
        check("alu_ready", in_ready, 1);
        in_valid = 1; in_is_load = 0; in_rd = rd; in_wr_en = wr; in_result = res;
        in_funct3 = 3'($urandom); mem_ack = 1'($urandom); mem_rdata = $urandom;
        @(negedge clk);
        we = wr && (rd != 0);
        if (we) begin exp_sel = rd; exp_data = res; end
        check("alu_wr", rf_write, we);
        check("alu_sel", rf_sel_write_reg, exp_sel);
        check("alu_data", rf_data_in, exp_data);
        check("alu_req", mem_req, 0);
        check("alu_err", load_err, 0);
    endtask

    task automatic idle_cycle();
        in_valid = 0; mem_ack = 1'($urandom);
        @(negedge clk);
        check("idle_wr", rf_write, 0);
        check("idle_ready", in_ready, 1);
    endtask

    task automatic load_op(input logic [4:0] rd, input logic wr, input logic [31:0] addr,
                           input logic [2:0] f3, input logic [31:0] word, input int delay);
        bit we;
        check("ld_ready", in_ready, 1);
        in_valid = 1; in_is_load = 1; in_rd = rd; in_wr_en = wr; in_result = addr; in_funct3 = f3;
        mem_ack = 1'($urandom);
        @(negedge clk);
        in_valid = 0; in_rd = 5'($urandom); in_result = $urandom;
        if (ref_misaligned(f3, addr)) begin
            mem_ack = 0;
            check("trap_err", load_err, 1);
            check("trap_req", mem_req, 0);
            check("trap_wr", rf_write, 0);
            check("trap_ready", in_ready, 1);
            @(negedge clk);
            check("trap_err_pulse", load_err, 0);
            check("trap_req2", mem_req, 0);
            return;
        end
        check("ld_req", mem_req, 1);
        check("ld_addr", mem_addr, addr & 32'hFFFF_FFFC);
        check("ld_busy", busy, 1);
        check("ld_wr_early", rf_write, 0);
        for (int d = 0; d < delay; d++) begin
            mem_ack = 0; mem_rdata = $urandom; in_valid = 1'($urandom);
            @(negedge clk);
            check("ld_wait_req", mem_req, 1);
            check("ld_wait_addr", mem_addr, addr & 32'hFFFF_FFFC);
            check("ld_wait_ready", in_ready, 0);
            check("ld_wait_wr", rf_write, 0);
        end
        in_valid = 0; mem_ack = 1; mem_rdata = word;
        @(negedge clk);
        mem_ack = 0; mem_rdata = $urandom;
        we = wr && (rd != 0);
        if (we) begin exp_sel = rd; exp_data = ref_load(word, f3, addr); end
        check("ld_wr", rf_write, we);
        check("ld_sel", rf_sel_write_reg, exp_sel);
        check("ld_data", rf_data_in, exp_data);
        check("ld_req_done", mem_req, 0);
        check("ld_busy_done", busy, 0);
        check("ld_ready_done", in_ready, 1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_req", mem_req, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wr", rf_write, 0);
        check("rst_sel", rf_sel_write_reg, 0);
        check("rst_data", rf_data_in, 0);
        check("rst_err", load_err, 0);
        check("rst_busy", busy, 0);
        reset = 0;
        @(negedge clk);

        alu_op(5'd5, 1, 32'h11);
        alu_op(5'd6, 1, 32'h22);
        alu_op(5'd7, 1, 32'h33);
        idle_cycle();

        load_op(5'd9, 1, 32'h1003, 3'b000, 32'h80FF_1234, 3);
        check("lb_value", rf_data_in, 32'hFFFF_FF80);
        load_op(5'd10, 1, 32'h2002, 3'b101, 32'hBEEF_0000, 0);
        check("lhu_value", rf_data_in, 32'h0000_BEEF);
        load_op(5'd11, 1, 32'h2002, 3'b001, 32'hBEEF_0000, 0);
        check("lh_value", rf_data_in, 32'hFFFF_BEEF);

        alu_op(5'd0, 1, 32'hDEAD_BEEF);
        alu_op(5'd12, 1, 32'h0000_0042);
        idle_cycle();

        // Reset while a load is outstanding; late ack must be ignored.
        in_valid = 1; in_is_load = 1; in_rd = 5'd13; in_wr_en = 1; in_result = 32'h4000; in_funct3 = 3'b010;
        @(negedge clk);
        in_valid = 0;
        check("mr_req", mem_req, 1);
        reset = 1;
        @(negedge clk);
        reset = 0; mem_ack = 1; mem_rdata = 32'h5555_AAAA;
        exp_sel = 0; exp_data = 0;
        check("mr_req0", mem_req, 0);
        check("mr_busy0", busy, 0);
        check("mr_wr0", rf_write, 0);
        @(negedge clk);
        mem_ack = 0;
        check("mr_wr1", rf_write, 0);
        check("mr_req1", mem_req, 0);
        check("mr_ready", in_ready, 1);
        alu_op(5'd14, 1, 32'h1234_5678);
        idle_cycle();

        load_op(5'd15, 1, 32'h3001, 3'b010, 32'hCAFE_F00D, 1);
`ifndef WB_MISALIGN_TRAP_EN
        check("lw_mis_value", rf_data_in, 32'hCAFE_F00D);
`endif

        for (int i = 0; i < 300; i++) begin
            logic [4:0] rd;
            rd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            case ($urandom_range(0, 3))
                0, 1: alu_op(rd, 1'($urandom), $urandom);
                2:    load_op(rd, 1'($urandom), $urandom, 3'($urandom), $urandom,
                              int'($urandom_range(0, 3)));
                default: idle_cycle();
            endcase
        end
        idle_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout total=%0d", total);
        $fatal(1, "timeout");
    end

endmodule
